rs232_tx_fifo: RTL and testbench
================================

# rs232_tx_fifo

Buffered RS-232 transmitter: accepts bytes on a valid/ready handshake into a DEPTH-entry FIFO and serialises them 8N1 (optional parity) on `tx`, LSB first, each bit held exactly PERIOD clocks. Queued bytes go out back-to-back with no idle gap between frames. It sits between on-chip producers (PDM result streams, command responses) and the board UART pin, replacing free-running transmission with flow-controlled, glitch-free framing.

## Interface
- PERIOD, 10: clock cycles per bit; must be at least 2.
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- PARITY, 0: 0 = no parity bit, 1 = even parity, 2 = odd parity.
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_data  in  8  byte to enqueue.
- in_valid  in  1  producer has a byte on in_data.
- in_ready  out  1  FIFO can accept; high when level < DEPTH.
- tx  out  1  serial line, registered, idles high.
- busy  out  1  high when the FSM is not IDLE or level != 0.
- level  out  $clog2(DEPTH)+1  bytes currently queued (0..DEPTH).

## Operation
- Reset (async assert, sync-free deassert) sets: tx=1, level=0, in_ready=1, busy=0, FSM=IDLE, bit and cycle counters = 0. FIFO contents are discarded. Reset mid-frame drives tx high immediately and the partial frame is lost.
- Push: a byte is written on any edge where in_valid && in_ready. The producer must hold in_data and in_valid until accepted.
- Full FIFO: in_ready=0 and there is no bypass. A pop on the same edge frees a slot only from the next cycle onward.
- Simultaneous push and pop: level is unchanged; write and read pointers both advance. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: tx=1. If level != 0: pop into the shift register, load the parity accumulator, go to START.
  - START: tx=0 for PERIOD cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for PERIOD cycles, then shift right. After bit 7, go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: tx = ^byte for even parity, or ~^byte for odd parity, for PERIOD cycles, then go to STOP.
  - STOP: tx=1 for PERIOD cycles. At its final cycle, if level != 0, pop and go directly to START. Otherwise go to IDLE.
- Cycle counter width is $clog2(PERIOD)+1. It counts 0..PERIOD-1, and the state advances on the edge where the count equals PERIOD-1.
- tx is taken from a register that is updated on the same edge as the state change. No combinational path from the FSM to the pin.
- in_data is sampled only at push. Changing it afterwards has no effect on queued bytes.

## Timing
- Push-to-line latency from an empty, idle block: push accepted at edge k, level=1 after edge k, tx falls at edge k+1.
- Frame length: 10*PERIOD cycles with no parity, 11*PERIOD with parity.
- Back-to-back frames: the start bit of the next byte begins on the edge immediately after the last stop-bit cycle. Zero idle cycles.
- level decrements on the pop edge, which is the same edge tx goes low for that byte.
- busy falls on the edge where STOP exits to IDLE with an empty FIFO.
- in_ready rises the cycle after a pop from a full FIFO.

## Test plan
- Reset values: hold resetn=0, then release. Required: tx=1, in_ready=1, busy=0, level=0. Assert resetn mid-DATA: tx=1 in the same cycle, level=0.
- Single byte, PERIOD=4, PARITY=0, push 0xA5. Required, 4 clocks per bit: tx = 0, 1,0,1,0,0,1,0,1, 1, then idle high. tx falls exactly 1 cycle after the push edge. busy low after 40 cycles.
- Parity, PERIOD=4, push 0xA5 then 0x01. With PARITY=1 the parity bits are 0 then 1. With PARITY=2 they are 1 then 0. Each frame is 44 cycles.
- Fill and backpressure, DEPTH=4, hold in_valid high with 0x10..0x15. Required: 0x10 is popped at once, 0x11..0x14 fill the FIFO, in_ready=0 at level=4, 0x15 is accepted only after the next pop. All six bytes go out in order.
- Back-to-back: queue 0x00 and 0xFF. Required: the last stop-bit cycle of frame 1 is immediately followed by tx=0 for frame 2, with no extra high cycle. Total high time is exactly PERIOD between the last data bit of 0x00 and the start bit of 0xFF.
- Simultaneous push and pop at level=2 during the STOP-to-START transition. Required: level stays 2 and the byte order is preserved across pointer wrap (more than 2*DEPTH bytes streamed).

Source files
------------

// File: rtl/rs232_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rs232_tx_fifo
// Description : Buffered RS-232 transmitter. Bytes enter a DEPTH-entry FIFO
//               over a valid/ready handshake and are serialised 8N1 (with
//               optional even/odd parity) on a registered, idle-high tx pin,
//               LSB first, PERIOD clocks per bit, frames back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_tx_fifo #(
  parameter int PERIOD = 10,
  parameter int DEPTH  = 4,
  parameter int PARITY = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PERIOD) + 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_acc;

  logic          push;
  logic          pop;
  logic          bit_end;
  logic          par_bit;
  logic [7:0]    pop_byte;

  // No bypass: a slot freed by a pop only becomes visible once level drops.
  assign in_ready = (level < LEVEL_FULL);
  assign push     = in_valid && in_ready;
  assign bit_end  = (cnt == CNT_LAST);
  assign pop_byte = mem[rd_ptr];

  // A byte leaves the FIFO either from IDLE or on the last STOP cycle, so
  // the next start bit follows the previous stop bit with no gap.
  assign pop  = (level != '0) &&
                ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign busy = (state != S_IDLE) || (level != '0);

  // The accumulator holds even parity; odd parity is its complement.
  generate
    if (PARITY == 2) begin : g_odd_parity
      assign par_bit = ~par_acc;
    end else begin : g_even_parity
      assign par_bit = par_acc;
    end
  endgenerate

  // FIFO storage: written only on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Framing FSM; tx is registered and changes on the same edge as the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_acc <= 1'b0;
      tx      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          tx  <= 1'b1;
          if (pop) begin
            shift   <= pop_byte;
            par_acc <= ^pop_byte;
            state   <= S_START;
            tx      <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            tx      <= shift[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= S_STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift   <= pop_byte;
              par_acc <= ^pop_byte;
              state   <= S_START;
              tx      <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          cnt   <= '0;
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs232_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_tx_fifo
// Description : Self-checking bench for rs232_tx_fifo. Three instances
//               (no parity, even, odd) at PERIOD=4, DEPTH=4 are compared
//               against a frame-level reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_tx_fifo;

  localparam int P     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] in_valid;
  logic [7:0] in_data [3];
  wire  [2:0] tx;
  wire  [2:0] in_ready;
  wire  [2:0] busy;
  wire  [2:0] level [3];

  int checks = 0;
  int failures = 0;

  // Instance g uses PARITY = g (0 none, 1 even, 2 odd).
  for (genvar g = 0; g < 3; g++) begin : g_dut
    rs232_tx_fifo #(.PERIOD(P), .DEPTH(DEPTH), .PARITY(g)) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .tx       (tx[g]),
      .busy     (busy[g]),
      .level    (level[g])
    );
  end

  always #5 clk = ~clk;

  // Reference model: log of accepted bytes, read count, and the position
  // (in clocks) inside the frame currently on the line (-1 = line idle).
  logic [7:0] m_hist [3][1024];
  int         m_wr  [3] = '{0, 0, 0};
  int         m_rd  [3] = '{0, 0, 0};
  int         m_pos [3] = '{-1, -1, -1};
  logic [7:0] m_cur [3] = '{8'h00, 8'h00, 8'h00};
  bit         fin;
  bit         acc;

  function automatic int flen(int i);
    return (i == 0) ? 10 : 11;
  endfunction

  function automatic logic exp_tx(int i);
    int b;
    if (m_pos[i] < 0) return 1'b1;
    b = m_pos[i] / P;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[i][3'(b - 1)];
    if (b == 9 && i == 1) return ^m_cur[i];
    if (b == 9 && i == 2) return ~^m_cur[i];
    return 1'b1;
  endfunction

  function automatic logic [2:0] exp_level(int i);
    return 3'(m_wr[i] - m_rd[i]);
  endfunction

  function automatic logic exp_busy(int i);
    return (m_pos[i] >= 0) || (m_wr[i] != m_rd[i]);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        m_wr[i]  = 0;
        m_rd[i]  = 0;
        m_pos[i] = -1;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        fin = (m_pos[i] == flen(i) * P - 1);
        acc = in_valid[i] && ((m_wr[i] - m_rd[i]) < DEPTH);
        if ((m_pos[i] < 0 || fin) && (m_wr[i] != m_rd[i])) begin
          m_cur[i] = m_hist[i][10'(m_rd[i])];
          m_rd[i]++;
          m_pos[i] = 0;
        end else if (fin) begin
          m_pos[i] = -1;
        end else if (m_pos[i] >= 0) begin
          m_pos[i]++;
        end
        if (acc) begin
          m_hist[i][10'(m_wr[i])] = in_data[i];
          m_wr[i]++;
        end
      end
    end
  end

  task automatic test_reset();
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        resetn = 1'b1;
        repeat (2) @(negedge clk);
      end else begin
        resetn = 1'b0;
        repeat (3) @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tx[i] !== 1'b1) begin failures++; $display("FAIL reset_tx[%0d] ph=%0d got=%b exp=1", i, ph, tx[i]); end
        checks++;
        if (in_ready[i] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d] ph=%0d got=%b exp=1", i, ph, in_ready[i]); end
        checks++;
        if (busy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] ph=%0d got=%b exp=0", i, ph, busy[i]); end
        checks++;
        if (level[i] !== 3'd0) begin failures++; $display("FAIL reset_level[%0d] ph=%0d got=%0d exp=0", i, ph, level[i]); end
      end
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] pat;
    logic       e;
    pat = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    in_data[0]  = 8'hA5;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    checks++;
    if (level[0] !== 3'd1) begin failures++; $display("FAIL single_level_after_push got=%0d exp=1", level[0]); end
    checks++;
    if (tx[0] !== 1'b1) begin failures++; $display("FAIL single_tx_at_push got=%b exp=1", tx[0]); end
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      e = (c < 40) ? pat[c / P] : 1'b1;
      checks++;
      if (tx[0] !== e) begin failures++; $display("FAIL single_tx c=%0d got=%b exp=%b", c, tx[0], e); end
      checks++;
      if (busy[0] !== (c < 40)) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy[0], (c < 40)); end
    end
  endtask

  task automatic test_parity();
    logic rec [3][100];
    @(negedge clk);
    in_data[1] = 8'hA5; in_data[2] = 8'hA5;
    in_valid[1] = 1'b1; in_valid[2] = 1'b1;
    @(negedge clk);
    in_data[1] = 8'h01; in_data[2] = 8'h01;
    @(negedge clk);
    in_valid[1] = 1'b0; in_valid[2] = 1'b0;
    for (int c = 0; c < 96; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        rec[i][c] = tx[i];
        checks++;
        if (tx[i] !== exp_tx(i)) begin failures++; $display("FAIL parity_tx[%0d] c=%0d got=%b exp=%b", i, c, tx[i], exp_tx(i)); end
        checks++;
        if (level[i] !== exp_level(i)) begin failures++; $display("FAIL parity_level[%0d] c=%0d got=%0d exp=%0d", i, c, level[i], exp_level(i)); end
        checks++;
        if (busy[i] !== exp_busy(i)) begin failures++; $display("FAIL parity_busy[%0d] c=%0d got=%b exp=%b", i, c, busy[i], exp_busy(i)); end
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (rec[i][37] !== (i == 2)) begin failures++; $display("FAIL parity_bit_a5[%0d] got=%b exp=%b", i, rec[i][37], (i == 2)); end
      checks++;
      if (rec[i][81] !== (i == 1)) begin failures++; $display("FAIL parity_bit_01[%0d] got=%b exp=%b", i, rec[i][81], (i == 1)); end
      checks++;
      if (rec[i][43] !== 1'b1 || rec[i][44] !== 1'b0) begin
        failures++; $display("FAIL parity_frame_len[%0d] got=%b%b exp=10", i, rec[i][43], rec[i][44]);
      end
    end
  endtask

  task automatic test_fill_backpressure();
    int n = 0;
    int push15 = -1;
    bit saw_full = 1'b0;
    bit accepting;
    @(negedge clk);
    in_data[0]  = 8'h10;
    in_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      accepting = in_valid[0] && in_ready[0];
      if (accepting && n == 5) push15 = cyc;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tx[i] !== exp_tx(i)) begin failures++; $display("FAIL fill_tx[%0d] t=%0t got=%b exp=%b", i, $time, tx[i], exp_tx(i)); end
        checks++;
        if (level[i] !== exp_level(i)) begin failures++; $display("FAIL fill_level[%0d] t=%0t got=%0d exp=%0d", i, $time, level[i], exp_level(i)); end
        checks++;
        if (in_ready[i] !== (exp_level(i) < 3'(DEPTH))) begin failures++; $display("FAIL fill_in_ready[%0d] t=%0t got=%b", i, $time, in_ready[i]); end
        checks++;
        if (busy[i] !== exp_busy(i)) begin failures++; $display("FAIL fill_busy[%0d] t=%0t got=%b exp=%b", i, $time, busy[i], exp_busy(i)); end
      end
      if (level[0] == 3'd4) begin
        saw_full = 1'b1;
        checks++;
        if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL fill_ready_when_full got=%b exp=0", in_ready[0]); end
      end
      if (accepting) begin
        n++;
        if (n < 6) in_data[0] = 8'(8'h10 + n);
        else in_valid[0] = 1'b0;
      end
      if (n == 6 && !busy[0] && !exp_busy(0)) break;
    end
    checks++;
    if (n != 6 || busy[0] !== 1'b0) begin failures++; $display("FAIL fill_complete accepted=%0d busy=%b exp=6,0", n, busy[0]); end
    checks++;
    if (!saw_full) begin failures++; $display("FAIL fill_reached_full got=0 exp=1"); end
    checks++;
    if (push15 != 42) begin failures++; $display("FAIL fill_push15_edge got=%0d exp=42", push15); end
  endtask

  task automatic test_back_to_back();
    logic rec [100];
    int   highs = 0;
    @(negedge clk);
    in_data[0]  = 8'h00;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_data[0] = 8'hFF;
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      rec[c] = tx[0];
      checks++;
      if (tx[0] !== exp_tx(0)) begin failures++; $display("FAIL b2b_tx c=%0d got=%b exp=%b", c, tx[0], exp_tx(0)); end
      checks++;
      if (level[0] !== exp_level(0)) begin failures++; $display("FAIL b2b_level c=%0d got=%0d exp=%0d", c, level[0], exp_level(0)); end
    end
    for (int c = 0; c < 40; c++) if (rec[c] === 1'b1) highs++;
    checks++;
    if (highs != P) begin failures++; $display("FAIL b2b_gap_high_cycles got=%0d exp=%0d", highs, P); end
    checks++;
    if (rec[39] !== 1'b1 || rec[40] !== 1'b0) begin failures++; $display("FAIL b2b_next_start got=%b%b exp=10", rec[39], rec[40]); end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b exp=0", busy[0]); end
  endtask

  task automatic test_simul_push_pop();
    int events = 0;
    bit pending = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      in_data[0]  = 8'($urandom);
      in_valid[0] = 1'b1;
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    checks++;
    if (level[0] !== 3'd2) begin failures++; $display("FAIL simul_prefill_level got=%0d exp=2", level[0]); end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      checks++;
      if (tx[0] !== exp_tx(0)) begin failures++; $display("FAIL simul_tx t=%0t got=%b exp=%b", $time, tx[0], exp_tx(0)); end
      checks++;
      if (busy[0] !== exp_busy(0)) begin failures++; $display("FAIL simul_busy t=%0t got=%b exp=%b", $time, busy[0], exp_busy(0)); end
      if (pending) begin
        checks++;
        if (level[0] !== 3'd2) begin failures++; $display("FAIL simul_level_hold t=%0t got=%0d exp=2", $time, level[0]); end
        pending = 1'b0;
      end
      in_valid[0] = 1'b0;
      if (events < 12 && m_pos[0] == flen(0) * P - 1 && exp_level(0) == 3'd2) begin
        in_data[0]  = 8'($urandom);
        in_valid[0] = 1'b1;
        pending = 1'b1;
        events++;
      end
      if (events == 12 && !pending && !busy[0] && !exp_busy(0)) break;
      @(negedge clk);
    end
    checks++;
    if (events != 12 || busy[0] !== 1'b0) begin failures++; $display("FAIL simul_complete events=%0d busy=%b exp=12,0", events, busy[0]); end
  endtask

  task automatic test_reset_mid_frame();
    int waited = 0;
    @(negedge clk);
    in_data[0]  = 8'h00;
    in_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    in_valid[0] = 1'b0;
    while (m_pos[0] != 3 * P && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx[0] !== 1'b0 || level[0] !== 3'd1) begin
      failures++; $display("FAIL midreset_before tx=%b level=%0d exp=0,1 waited=%0d", tx[0], level[0], waited);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1) begin failures++; $display("FAIL midreset_tx got=%b exp=1", tx[0]); end
    checks++;
    if (level[0] !== 3'd0) begin failures++; $display("FAIL midreset_level got=%0d exp=0", level[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy[0]); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++; $display("FAIL midreset_after tx=%b busy=%b exp=1,0", tx[0], busy[0]); end
    end
  endtask

  task automatic test_random();
    bit offer_ok [3] = '{1'b0, 1'b0, 1'b0};
    bit all_idle;
    int rate;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      all_idle = 1'b1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (tx[i] !== exp_tx(i)) begin failures++; $display("FAIL rand_tx[%0d] t=%0t got=%b exp=%b", i, $time, tx[i], exp_tx(i)); end
        checks++;
        if (level[i] !== exp_level(i)) begin failures++; $display("FAIL rand_level[%0d] t=%0t got=%0d exp=%0d", i, $time, level[i], exp_level(i)); end
        checks++;
        if (in_ready[i] !== (exp_level(i) < 3'(DEPTH))) begin failures++; $display("FAIL rand_in_ready[%0d] t=%0t got=%b", i, $time, in_ready[i]); end
        checks++;
        if (busy[i] !== exp_busy(i)) begin failures++; $display("FAIL rand_busy[%0d] t=%0t got=%b exp=%b", i, $time, busy[i], exp_busy(i)); end
        if (!(in_valid[i] && !offer_ok[i])) begin
          rate = (cyc < 750) ? 3 : 59;
          if (cyc < 1500 && $urandom_range(0, rate) == 0) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 8'($urandom);
          end else begin
            in_valid[i] = 1'b0;
          end
        end
        offer_ok[i] = in_ready[i];
        if (in_valid[i] || busy[i] || exp_busy(i)) all_idle = 1'b0;
      end
      if (cyc >= 1500 && all_idle) break;
      @(negedge clk);
    end
    checks++;
    if (busy !== 3'b000) begin failures++; $display("FAIL rand_drain busy=%b exp=000", busy); end
  endtask

  initial begin
    in_valid = '0;
    for (int i = 0; i < 3; i++) in_data[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_parity();
    test_fill_backpressure();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
